mem_arbiter: RTL

- Shares one single-port 8-bit program/data memory between two requesters: port 0 (CPU fetch/operand path) and port 1 (program loader / debug master).
- Sits between the CPU's memory interface and the memory model. Drives active-low read/write strobes in the same style as the CPU bus.
- Serialises accesses through a 3-state FSM with a programmable wait-state count. Arbitrates round-robin by default.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory: IDLE -> ACCESS -> DONE with programmable wait states.
// Round-robin on contention by default; define MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_R,
  output logic              mem_W,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               last_q, last_n;
  logic               win_q, win_n;
  logic               op_we_q, op_we_n;
  logic [1:0]         gnt_n, done_n;
  logic [DATA_W-1:0]  rdata_n;
  logic               mem_r_n, mem_w_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [DATA_W-1:0]  mem_wdata_n;
  logic               win_c;

  // Winner selection among current requesters
  always_comb begin
    win_c = 1'b0;
    case (req)
      2'b10: win_c = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11: win_c = 1'b0;
`else
      2'b11: win_c = ~last_q;
`endif
      default: win_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      op_we_q   <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_R     <= 1'b1;
      mem_W     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      last_q    <= last_n;
      win_q     <= win_n;
      op_we_q   <= op_we_n;
      gnt       <= gnt_n;
      done      <= done_n;
      rdata     <= rdata_n;
      mem_R     <= mem_r_n;
      mem_W     <= mem_w_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  // Next-state and next-output logic; strobes are registered so they track state exactly
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    last_n      = last_q;
    win_n       = win_q;
    op_we_n     = op_we_q;
    gnt_n       = gnt;
    done_n      = '0;
    rdata_n     = rdata;
    mem_r_n     = 1'b1;
    mem_w_n     = 1'b1;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win_n       = win_c;
          op_we_n     = we[win_c];
          mem_addr_n  = win_c ? addr1 : addr0;
          mem_wdata_n = win_c ? wdata1 : wdata0;
          gnt_n       = win_c ? 2'b10 : 2'b01;
          cnt_n       = CNT_W'(WAIT_STATES);
          mem_r_n     = we[win_c];
          mem_w_n     = ~we[win_c];
          state_n     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_n   = cnt_q - CNT_W'(1);
          mem_r_n = op_we_q;
          mem_w_n = ~op_we_q;
        end else begin
          if (!op_we_q) rdata_n = mem_rdata;
          gnt_n   = '0;
          done_n  = win_q ? 2'b10 : 2'b01;
          last_n  = win_q;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
